// File: rtl/perf_counter_multi.sv
// Multi-section cycle/event performance counter on an Avalon-MM slave; 1-cycle registered read latency.
// No backpressure: every strobe is accepted on the edge that samples it (no waitrequest).
module perf_counter_multi #(
  parameter int NUM_SECTIONS = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int TIME_WIDTH   = 64,
  parameter int EVENT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  begintransfer,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata
);

  localparam int SW = ADDR_WIDTH - 2;
  localparam int HW = TIME_WIDTH - 32;

  logic          wr_stb, rd_stb, glb_hit, glb_clr;
  logic [SW-1:0] sec;
  logic [1:0]    off;
  logic          unused_wdata;

  logic [NUM_SECTIONS-1:0] sec_hit, stop_hit, start_hit, stat_hit, rd0_hit, t_inc, e_inc;

  logic [NUM_SECTIONS-1:0][TIME_WIDTH-1:0]  time_q, time_d;
  logic [NUM_SECTIONS-1:0][HW-1:0]          snap_q, snap_d;
  logic [NUM_SECTIONS-1:0][EVENT_WIDTH-1:0] event_q, event_d;
  logic [NUM_SECTIONS-1:0]                  enable_q, enable_d;
  logic [NUM_SECTIONS-1:0]                  tovf_q, tovf_d;
  logic [NUM_SECTIONS-1:0]                  eovf_q, eovf_d;
  logic                                     freeze_q, freeze_d;
  logic [31:0]                              readdata_q, readdata_d;

  assign wr_stb       = write & begintransfer;
  assign rd_stb       = read & begintransfer;
  assign sec          = address[ADDR_WIDTH-1:2];
  assign off          = address[1:0];
  assign glb_hit      = (address == ADDR_WIDTH'(4 * NUM_SECTIONS));
  assign unused_wdata = ^writedata[31:3];
  assign readdata     = readdata_q;

  always_comb begin
    sec_hit   = '0;
    stop_hit  = '0;
    start_hit = '0;
    stat_hit  = '0;
    rd0_hit   = '0;
    t_inc     = '0;
    e_inc     = '0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      sec_hit[i]   = (sec == SW'(i));
      stop_hit[i]  = wr_stb && sec_hit[i] && (off == 2'd0);
      start_hit[i] = wr_stb && sec_hit[i] && (off == 2'd1);
      stat_hit[i]  = wr_stb && sec_hit[i] && (off == 2'd3);
      rd0_hit[i]   = rd_stb && sec_hit[i] && (off == 2'd0);
      // A STOP sampled this cycle already suppresses this cycle's tick.
      t_inc[i]     = enable_q[i] && !freeze_q && !stop_hit[i];
      e_inc[i]     = start_hit[i] && !freeze_q;
    end
    glb_clr = |stop_hit && writedata[0];
  end

  always_comb begin
    time_d     = time_q;
    snap_d     = snap_q;
    event_d    = event_q;
    enable_d   = enable_q;
    tovf_d     = tovf_q;
    eovf_d     = eovf_q;
    freeze_d   = freeze_q;
    readdata_d = readdata_q;

    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (t_inc[i]) time_d[i] = time_q[i] + TIME_WIDTH'(1);
      if (e_inc[i]) event_d[i] = event_q[i] + EVENT_WIDTH'(1);
      if (start_hit[i]) enable_d[i] = 1'b1;
      if (stop_hit[i]) enable_d[i] = 1'b0;
      // The overflow set term is OR-ed last so it beats a coincident W1C.
      tovf_d[i] = (tovf_q[i] & ~(stat_hit[i] & writedata[1])) | (t_inc[i] & (&time_q[i]));
      eovf_d[i] = (eovf_q[i] & ~(stat_hit[i] & writedata[2])) | (e_inc[i] & (&event_q[i]));
      if (rd0_hit[i]) snap_d[i] = time_q[i][TIME_WIDTH-1:32];
    end

    if (wr_stb && glb_hit) freeze_d = writedata[0];

    if (rd_stb) begin
      readdata_d = '0;
      if (glb_hit) readdata_d = {31'b0, freeze_q};
      for (int i = 0; i < NUM_SECTIONS; i++) begin
        if (sec_hit[i]) begin
          case (off)
            2'd0:    readdata_d = time_q[i][31:0];
            2'd1:    readdata_d = 32'(snap_q[i]);
            2'd2:    readdata_d = 32'(event_q[i]);
            default: readdata_d = {29'b0, eovf_q[i], tovf_q[i], enable_q[i]};
          endcase
        end
      end
    end

    if (glb_clr) begin
      time_d   = '0;
      snap_d   = '0;
      event_d  = '0;
      enable_d = '0;
      tovf_d   = '0;
      eovf_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      time_q     <= '0;
      snap_q     <= '0;
      event_q    <= '0;
      enable_q   <= '0;
      tovf_q     <= '0;
      eovf_q     <= '0;
      freeze_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      time_q     <= time_d;
      snap_q     <= snap_d;
      event_q    <= event_d;
      enable_q   <= enable_d;
      tovf_q     <= tovf_d;
      eovf_q     <= eovf_d;
      freeze_q   <= freeze_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_perf_counter_multi.sv
// Bench for perf_counter_multi: directed scenarios then random bus traffic against a transaction-level model.
module tb_perf_counter_multi;

  localparam int NS = 4;
  localparam int AW = 6;
  localparam int TW = 33;
  localparam int EW = 3;
  localparam logic [63:0] TMASK = (64'd1 << TW) - 64'd1;
  localparam int EMOD = 1 << EW;
  localparam int GADDR = 4 * NS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          begintransfer = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;

  logic [NS-1:0][TW-1:0] tv;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: time values as plain integers, flags as bits.
  logic [63:0] m_time[NS];
  logic [63:0] m_snap[NS];
  int          m_event[NS];
  bit          m_en[NS], m_tovf[NS], m_eovf[NS];
  bit          m_frz;
  logic [31:0] m_rd;

  perf_counter_multi #(
    .NUM_SECTIONS(NS), .ADDR_WIDTH(AW), .TIME_WIDTH(TW), .EVENT_WIDTH(EW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .begintransfer(begintransfer),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic void m_clear_counters();
    for (int s = 0; s < NS; s++) begin
      m_time[s] = 0; m_snap[s] = 0; m_event[s] = 0;
      m_en[s] = 0; m_tovf[s] = 0; m_eovf[s] = 0;
    end
  endfunction

  function automatic void m_reset();
    m_clear_counters();
    m_frz = 0;
    m_rd  = 0;
  endfunction

  // Advance n clock edges; 'skip' names a section whose STOP lands on this edge.
  function automatic void m_advance(input int n, input int skip);
    for (int s = 0; s < NS; s++) begin
      if (m_en[s] && !m_frz && s != skip) begin
        logic [63:0] t;
        t = m_time[s] + 64'(n);
        if (t > TMASK) m_tovf[s] = 1;
        m_time[s] = t & TMASK;
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input int addr);
    int s, o;
    s = addr / 4;
    o = addr % 4;
    if (s < NS) begin
      case (o)
        0:       return m_time[s][31:0];
        1:       return m_snap[s][31:0];
        2:       return 32'(m_event[s]);
        default: return {29'b0, m_eovf[s], m_tovf[s], m_en[s]};
      endcase
    end
    if (addr == GADDR) return {31'b0, m_frz};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: readdata=%h expected=%h", tag, got, exp);
  endtask

  // One bus strobe occupying exactly one clock edge; readdata is checked on the following negedge.
  task automatic op(input bit wr, input int addr, input logic [31:0] wd, input string tag);
    int s, o;
    s = addr / 4;
    o = addr % 4;
    address = AW'(addr); begintransfer = 1'b1; read = !wr; write = wr; writedata = wd;
    if (!wr) begin
      m_rd = m_read(addr);
      if (s < NS && o == 0) m_snap[s] = m_time[s] >> 32;
    end else if (s < NS && o == 3) begin
      if (wd[1]) m_tovf[s] = 0;
      if (wd[2]) m_eovf[s] = 0;
    end
    m_advance(1, (wr && s < NS && o == 0) ? s : -1);
    if (wr && s < NS && o == 1) begin
      m_en[s] = 1;
      if (!m_frz) begin
        m_event[s]++;
        if (m_event[s] == EMOD) begin m_event[s] = 0; m_eovf[s] = 1; end
      end
    end
    if (wr && s < NS && o == 0) begin
      m_en[s] = 0;
      if (wd[0]) m_clear_counters();
    end
    if (wr && addr == GADDR) m_frz = wd[0];
    @(posedge clk);
    @(negedge clk);
    begintransfer = 1'b0; read = 1'b0; write = 1'b0;
    chk(tag, readdata, m_rd);
  endtask

  task automatic rd(input int addr, input string tag);
    op(1'b0, addr, 32'h0, tag);
  endtask

  task automatic wr(input int addr, input logic [31:0] wd, input string tag);
    op(1'b1, addr, wd, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    m_advance(n, -1);
  endtask

  // Preload one section's time counter; only used while that counter is not ticking.
  task automatic preload(input int s, input logic [TW-1:0] val);
    for (int k = 0; k < NS; k++) tv[k] = m_time[k][TW-1:0];
    tv[s] = val;
    force dut.time_q = tv;
    @(posedge clk);
    @(negedge clk);
    release dut.time_q;
    m_time[s] = 64'(val);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_readdata", readdata, 32'h0);

    for (int a = 0; a <= GADDR; a++) rd(a, $sformatf("reset_rd_a%0d", a));
    rd(20, "unmapped_20");
    rd(63, "unmapped_63");
    wr(40, 32'hFFFF_FFFF, "unmapped_wr");
    rd(40, "unmapped_rd_after_wr");

    wr(9, 32'h0, "s2_start");
    idle(100);
    wr(8, 32'h0, "s2_stop");
    rd(8, "s2_time_lo");
    chk("s2_time_is_100", readdata, 32'd100);
    rd(9, "s2_time_hi");
    rd(10, "s2_event");
    chk("s2_event_is_1", readdata, 32'd1);

    preload(0, 33'h0_FFFF_FFFE);
    wr(1, 32'h0, "s0_start");
    idle(1);
    rd(0, "s0_lo_before_carry");
    chk("s0_lo_all_ones", readdata, 32'hFFFF_FFFF);
    idle(9);
    rd(1, "s0_snap_not_torn");
    rd(0, "s0_lo_after_carry");
    rd(1, "s0_snap_after_carry");
    chk("s0_hi_is_1", readdata, 32'h1);
    wr(0, 32'h0, "s0_stop");

    preload(1, '1);
    wr(5, 32'h0, "s1_start");
    wr(GADDR, 32'h1, "freeze_on");
    rd(4, "s1_time_wrapped");
    rd(7, "s1_status_ovf");
    chk("s1_status_is_3", readdata, 32'h3);
    wr(7, 32'h2, "s1_w1c_tovf");
    rd(7, "s1_status_cleared");
    preload(1, '1);
    wr(GADDR, 32'h0, "freeze_off");
    wr(7, 32'h2, "s1_w1c_vs_set");
    wr(GADDR, 32'h1, "freeze_on2");
    rd(7, "s1_set_beats_clear");
    chk("s1_status_set_wins", readdata, 32'h3);
    wr(GADDR, 32'h0, "freeze_off2");
    wr(4, 32'h0, "s1_stop");

    for (int k = 0; k < EMOD; k++) wr(13, 32'h0, "s3_start");
    rd(14, "s3_event_wrapped");
    rd(15, "s3_status_eovf");
    wr(15, 32'h4, "s3_w1c_eovf");
    rd(15, "s3_status_eovf_cleared");
    wr(12, 32'h0, "s3_stop");

    wr(1, 32'h0, "gc_s0_start");
    wr(5, 32'h0, "gc_s1_start");
    idle(5);
    wr(4, 32'h1, "gc_clear");
    for (int s = 0; s < NS; s++) begin
      rd(4 * s + 3, $sformatf("gc_status_s%0d", s));
      rd(4 * s, $sformatf("gc_time_s%0d", s));
      rd(4 * s + 2, $sformatf("gc_event_s%0d", s));
    end

    wr(GADDR, 32'h1, "frz_set");
    for (int k = 0; k < 3; k++) wr(1, 32'h0, "frz_s0_start");
    idle(50);
    rd(2, "frz_event");
    rd(0, "frz_time");
    rd(3, "frz_status");
    rd(GADDR, "frz_reg");
    wr(GADDR, 32'h0, "frz_clear");
    idle(5);
    rd(0, "unfrz_time");
    chk("unfrz_time_is_5", readdata, 32'd5);
    wr(0, 32'h0, "unfrz_stop");

    for (int i = 0; i < 400; i++) begin
      int k, sec;
      k = $urandom_range(0, 15);
      sec = $urandom_range(0, NS - 1);
      if (k <= 5)       rd($urandom_range(0, GADDR + 3), "rnd_rd");
      else if (k <= 8)  wr(4 * sec + 1, $urandom, "rnd_start");
      else if (k == 9)  wr(4 * sec, {31'b0, ($urandom_range(0, 15) == 0)}, "rnd_stop");
      else if (k == 10) wr(4 * sec, 32'h0, "rnd_stop0");
      else if (k == 11) wr(4 * sec + 3, $urandom, "rnd_w1c");
      else if (k == 12) wr(GADDR, {31'b0, ($urandom_range(0, 3) == 0)}, "rnd_frz");
      else              idle($urandom_range(1, 20));
    end
    for (int a = 0; a <= GADDR; a++) rd(a, "rnd_final");

    address = AW'(0); begintransfer = 1'b1; read = 1'b1; reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    begintransfer = 1'b0; read = 1'b0; reset_n = 1'b1;
    m_reset();
    chk("midxfer_reset_readdata", readdata, 32'h0);
    for (int a = 0; a <= GADDR; a++) rd(a, "post_reset_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
